// File: rtl/neuron_a_feeder_pkg.sv
// ============================================================================
// Module      : neuron_a_feeder_pkg
// Description : Q-format constants, FSM encoding and config addresses for
//               neuron_a_feeder.
// Revision    : 1.0
// ============================================================================
`ifndef NEURON_A_FEEDER_PKG_SV
`define NEURON_A_FEEDER_PKG_SV
`default_nettype none

package neuron_a_feeder_pkg;

    localparam int          Q_WIDTH   = 32;
    localparam int          Q_FBITS   = 24;
    localparam logic [31:0] Q_ONE     = 32'h0100_0000;
    localparam logic [31:0] Q_NEG_ONE = 32'hFF00_0000;

    typedef enum logic [2:0] {
        COLLECT = 3'd0,
        FIRE1   = 3'd1,
        FIRE2   = 3'd2,
        CAPTURE = 3'd3,
        OUT     = 3'd4
    } state_e;

    localparam logic [1:0] CFG_W1 = 2'd0;
    localparam logic [1:0] CFG_W2 = 2'd1;
    localparam logic [1:0] CFG_W3 = 2'd2;
    localparam logic [1:0] CFG_B  = 2'd3;

endpackage

`default_nettype wire
`endif

// File: rtl/neuron_a_feeder_if.sv
// ============================================================================
// Module      : neuron_a_feeder_if
// Description : Sample stream, config port, neuron_a drive and result stream.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface neuron_a_feeder_if
    import neuron_a_feeder_pkg::*;
#(
    parameter int WIDTH = Q_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             cfg_wr;
    logic [1:0]       cfg_addr;
    logic [WIDTH-1:0] cfg_data;
    logic             n_en;
    logic [WIDTH-1:0] n_a1;
    logic [WIDTH-1:0] n_a2;
    logic [WIDTH-1:0] n_a3;
    logic [WIDTH-1:0] n_w1;
    logic [WIDTH-1:0] n_w2;
    logic [WIDTH-1:0] n_w3;
    logic [WIDTH-1:0] n_b;
    logic [WIDTH-1:0] n_y;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;

    modport slave (
        input  in_valid, in_data, cfg_wr, cfg_addr, cfg_data, n_y, out_ready,
        output in_ready, n_en, n_a1, n_a2, n_a3, n_w1, n_w2, n_w3, n_b,
               out_valid, out_data, busy
    );

    modport master (
        output in_valid, in_data, cfg_wr, cfg_addr, cfg_data, n_y, out_ready,
        input  in_ready, n_en, n_a1, n_a2, n_a3, n_w1, n_w2, n_w3, n_b,
               out_valid, out_data, busy
    );
endinterface

`default_nettype wire

// File: rtl/neuron_a_feeder_q_clamp.sv
// ============================================================================
// Module      : q_clamp
// Description : Combinational signed saturation of a Q value to [-1.0, +1.0].
// Revision    : 1.0
// ============================================================================
`default_nettype none

module q_clamp #(
    parameter int WIDTH = 32,
    parameter int FBITS = 24
) (
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);
    localparam logic signed [WIDTH-1:0] C_ONE     = {{(WIDTH-FBITS-1){1'b0}}, 1'b1, {FBITS{1'b0}}};
    localparam logic signed [WIDTH-1:0] C_NEG_ONE = -C_ONE;

    always_comb begin
        data_o = data_i;
        if ($signed(data_i) > C_ONE) begin
            data_o = C_ONE;
        end else if ($signed(data_i) < C_NEG_ONE) begin
            data_o = C_NEG_ONE;
        end
    end
endmodule

`default_nettype wire

// File: rtl/neuron_a_feeder.sv
// ============================================================================
// Module      : neuron_a_feeder
// Description : Packs three streamed activations, fires neuron_a for two
//               cycles, latches y and returns it over valid/ready.
//               Optional input clamp: define NEURON_FEED_CLAMP_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module neuron_a_feeder
    import neuron_a_feeder_pkg::*;
#(
    parameter int WIDTH = Q_WIDTH,
    parameter int FBITS = Q_FBITS
) (
    input  logic            clk,
    input  logic            rst,
    neuron_a_feeder_if.slave bus
);
    state_e           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] a1_q, a2_q, a3_q;
    logic [WIDTH-1:0] w1_q, w2_q, w3_q, b_q;
    logic [WIDTH-1:0] out_q;

    logic [WIDTH-1:0] w_sample;
    logic             w_accept;
    logic             w_cfg_we;

`ifdef NEURON_FEED_CLAMP_EN
    q_clamp #(
        .WIDTH (WIDTH),
        .FBITS (FBITS)
    ) u_q_clamp (
        .data_i (bus.in_data),
        .data_o (w_sample)
    );
`else
    logic w_unused_fbits;
    assign w_unused_fbits = ^FBITS;
    assign w_sample       = bus.in_data;
`endif

    assign w_accept = bus.in_valid && (state_q == COLLECT);
    assign w_cfg_we = bus.cfg_wr && (state_q == COLLECT);

    assign bus.in_ready  = (state_q == COLLECT);
    assign bus.n_en      = (state_q == FIRE1) || (state_q == FIRE2);
    assign bus.out_valid = (state_q == OUT);
    assign bus.out_data  = out_q;
    assign bus.busy      = !((state_q == COLLECT) && (cnt_q == 2'd0));
    assign bus.n_a1      = a1_q;
    assign bus.n_a2      = a2_q;
    assign bus.n_a3      = a3_q;
    assign bus.n_w1      = w1_q;
    assign bus.n_w2      = w2_q;
    assign bus.n_w3      = w3_q;
    assign bus.n_b       = b_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            COLLECT: begin
                if (w_accept) begin
                    if (cnt_q == 2'd2) begin
                        cnt_d   = 2'd0;
                        state_d = FIRE1;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            FIRE1:   state_d = FIRE2;
            FIRE2:   state_d = CAPTURE;
            CAPTURE: state_d = OUT;
            OUT: begin
                if (bus.out_ready) begin
                    state_d = COLLECT;
                end
            end
            default: begin
                state_d = COLLECT;
                cnt_d   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= COLLECT;
            cnt_q   <= 2'd0;
            a1_q    <= '0;
            a2_q    <= '0;
            a3_q    <= '0;
            w1_q    <= '0;
            w2_q    <= '0;
            w3_q    <= '0;
            b_q     <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (w_accept) begin
                case (cnt_q)
                    2'd0:    a1_q <= w_sample;
                    2'd1:    a2_q <= w_sample;
                    default: a3_q <= w_sample;
                endcase
            end
            if (w_cfg_we) begin
                case (bus.cfg_addr)
                    CFG_W1: w1_q <= bus.cfg_data;
                    CFG_W2: w2_q <= bus.cfg_data;
                    CFG_W3: w3_q <= bus.cfg_data;
                    CFG_B:  b_q  <= bus.cfg_data;
                endcase
            end
            // n_y reflects the stage-2 sum registered on the FIRE2 edge.
            if (state_q == CAPTURE) begin
                out_q <= bus.n_y;
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_neuron_a_feeder.sv
// ============================================================================
// Module      : tb_neuron_a_feeder
// Description : Scoreboard bench for neuron_a_feeder with a neuron_a stand-in.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_neuron_a_feeder;
    import neuron_a_feeder_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    neuron_a_feeder_if #(.WIDTH(32)) bus ();

    neuron_a_feeder #(.WIDTH(32), .FBITS(24)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string nm, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (t=%0t)", nm, act, req, $time);
        end
    endfunction

    // Q8.24 multiply, keeping the low word of the rescaled product
    function automatic logic [31:0] qmul(logic [31:0] a, logic [31:0] w);
        longint p;
        p = longint'($signed(a)) * longint'($signed(w));
        return 32'(p >>> 24);
    endfunction

    function automatic logic [31:0] clampf(logic [31:0] x);
`ifdef NEURON_FEED_CLAMP_EN
        if ($signed(x) > $signed(32'h0100_0000)) return 32'h0100_0000;
        if ($signed(x) < $signed(32'hFF00_0000)) return 32'hFF00_0000;
`endif
        return x;
    endfunction

    // neuron_a stand-in: stage 1 products/bias, stage 2 sum, y = sum
    logic [31:0] s1_p1 = '0, s1_p2 = '0, s1_p3 = '0, s1_b = '0, s2 = '0;
    always @(posedge clk) begin
        if (bus.n_en) begin
            s1_p1 <= qmul(bus.n_a1, bus.n_w1);
            s1_p2 <= qmul(bus.n_a2, bus.n_w2);
            s1_p3 <= qmul(bus.n_a3, bus.n_w3);
            s1_b  <= bus.n_b;
            s2    <= s1_p1 + s1_p2 + s1_p3 + s1_b;
        end
    end
    assign bus.n_y = s2;

    // out_ready source
    logic rand_rdy = 1'b0;
    logic hold_rdy = 1'b1;
    logic rnd_rdy  = 1'b1;
    always @(posedge clk) begin
        #1;
        rnd_rdy = ($urandom_range(0, 3) != 0);
    end
    assign bus.out_ready = rand_rdy ? rnd_rdy : hold_rdy;

    // Reference model
    logic [31:0] m_w [3];
    logic [31:0] m_b;
    logic [31:0] m_a [$];
    logic [31:0] exp_q [$];
    int          lat_q [$];
    int          n_pushed = 0;
    int          n_popped = 0;

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) m_w[i] = '0;
        m_b = '0;
        m_a.delete();
    endfunction

    // Monitor
    int   en_run  = 0;
    logic prev_ov = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            en_run  = 0;
            prev_ov = 1'b0;
        end else begin
            if (bus.n_en) begin
                en_run++;
            end else if (en_run != 0) begin
                check("n_en_cycles", 32'(en_run), 32'd2);
                en_run = 0;
            end
            if (bus.out_valid && !prev_ov) begin
                if (lat_q.size() != 0) begin
                    check("latency", 32'(cyc - lat_q.pop_front()), 32'd3);
                end else begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_out_valid: got 1 required 0");
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() != 0) begin
                    check("out_data", bus.out_data, exp_q.pop_front());
                    n_popped++;
                end else begin
                    n_cmp++; n_fail++;
                    $display("FAIL extra_result: got %h required none", bus.out_data);
                end
            end
            prev_ov = bus.out_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [31:0] data);
        bus.cfg_wr   = 1'b1;
        bus.cfg_addr = addr;
        bus.cfg_data = data;
        tick();
        bus.cfg_wr = 1'b0;
        if (addr == 2'd3) m_b = data;
        else              m_w[addr] = data;
    endtask

    task automatic send(input logic [31:0] d);
        bit ok;
        ok = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1;
                tick();
                break;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        if (!ok) begin
            n_cmp++; n_fail++;
            $display("FAIL accept_timeout: got in_ready 0 required 1");
        end else begin
            m_a.push_back(clampf(d));
            if (m_a.size() == 3) begin
                exp_q.push_back(qmul(m_a[0], m_w[0]) + qmul(m_a[1], m_w[1])
                                + qmul(m_a[2], m_w[2]) + m_b);
                lat_q.push_back(cyc);
                n_pushed++;
                m_a.delete();
            end
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        if (exp_q.size() != 0) begin
            n_cmp++; n_fail++;
            $display("FAIL drain_timeout: got %0d pending required 0", exp_q.size());
            exp_q.delete();
            lat_q.delete();
        end
    endtask

    function automatic logic [31:0] rand_q();
        case ($urandom_range(0, 2))
            0:       return $urandom();
            1:       return 32'($signed($urandom_range(0, 32'h0400_0000)) - 32'sh0200_0000);
            default: return 32'($urandom_range(0, 32'h0100_0000));
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.cfg_wr   = 1'b0;
        bus.cfg_addr = '0;
        bus.cfg_data = '0;
        model_reset();

        // Reset and idle
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_n_en",      32'(bus.n_en),      32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_busy",      32'(bus.busy),      32'd0);
        check("rst_n_a1", bus.n_a1, 32'h0);
        check("rst_n_a2", bus.n_a2, 32'h0);
        check("rst_n_a3", bus.n_a3, 32'h0);
        check("rst_n_w1", bus.n_w1, 32'h0);
        check("rst_n_w2", bus.n_w2, 32'h0);
        check("rst_n_w3", bus.n_w3, 32'h0);
        check("rst_n_b",  bus.n_b,  32'h0);
        check("rst_out_data", bus.out_data, 32'h0);
        tick();
        rst = 1'b0;

        // Basic pass: 3 x (1.0 * 0.5) = 1.5
        for (int i = 0; i < 3; i++) cfg_write(2'(i), 32'h0080_0000);
        cfg_write(2'd3, 32'h0);
        for (int i = 0; i < 3; i++) send(32'h0100_0000);
        wait_idle();

        // Backpressure with a waiting producer
        hold_rdy = 1'b0;
        for (int i = 0; i < 3; i++) send(32'h0040_0000 + 32'(i));
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h1234_5678;
        for (int i = 0; i < 3; i++) tick();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_in_ready",  32'(bus.in_ready),  32'd0);
            check("bp_n_en",      32'(bus.n_en),      32'd0);
            check("bp_out_data",  bus.out_data, exp_q[0]);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        hold_rdy     = 1'b1;
        wait_idle();
        @(negedge clk);
        check("bp_back_idle", 32'(bus.busy), 32'd0);
        tick();

        // Config write while firing is ignored; in COLLECT it lands
        for (int i = 0; i < 3; i++) send(32'h0020_0000);
        bus.cfg_wr   = 1'b1;
        bus.cfg_addr = 2'd3;
        bus.cfg_data = 32'h0040_0000;
        tick();
        bus.cfg_wr = 1'b0;
        @(negedge clk);
        check("busy_cfg_n_b", bus.n_b, m_b);
        wait_idle();
        cfg_write(2'd3, 32'h0040_0000);
        @(negedge clk);
        check("idle_cfg_n_b", bus.n_b, 32'h0040_0000);
        tick();

        // Mid-vector reset
        send(32'h0011_0000);
        send(32'h0022_0000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check("mid_rst_n_a1", bus.n_a1, 32'h0);
        check("mid_rst_n_a2", bus.n_a2, 32'h0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        tick();
        cfg_write(2'd0, 32'h0100_0000);
        cfg_write(2'd1, 32'hFF80_0000);
        cfg_write(2'd2, 32'h0030_0000);
        for (int i = 0; i < 3; i++) send(32'h0090_0000 - 32'(i << 20));
        wait_idle();

        // Clamp boundary samples
        send(32'h0300_0000);
        send(32'hFD00_0000);
        send(32'h0080_0000);
        @(negedge clk);
        check("clamp_a1", bus.n_a1, clampf(32'h0300_0000));
        check("clamp_a2", bus.n_a2, clampf(32'hFD00_0000));
        check("clamp_a3", bus.n_a3, 32'h0080_0000);
        tick();
        wait_idle();

        // Randomized vectors with random backpressure and config churn
        rand_rdy = 1'b1;
        for (int v = 0; v < 30; v++) begin
            wait_idle();
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                cfg_write(2'($urandom_range(0, 3)), rand_q());
            end
            for (int s = 0; s < 3; s++) begin
                for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
                if (s == 0 && $urandom_range(0, 1) == 1) begin
                    logic [1:0]  ca;
                    logic [31:0] cd;
                    ca = 2'($urandom_range(0, 3));
                    cd = rand_q();
                    bus.cfg_wr   = 1'b1;
                    bus.cfg_addr = ca;
                    bus.cfg_data = cd;
                    if (ca == 2'd3) m_b = cd;
                    else            m_w[ca] = cd;
                    send(rand_q());
                    bus.cfg_wr = 1'b0;
                end else begin
                    send(rand_q());
                end
            end
        end
        rand_rdy = 1'b0;
        hold_rdy = 1'b1;
        wait_idle();
        for (int i = 0; i < 5; i++) tick();
        check("result_count", 32'(n_popped), 32'(n_pushed));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
